warmboot_ctrl: RTL

WARMBOOT_CTRL -- requirements
Module: warmboot_ctrl

---
 rtl/warmboot_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/warmboot_ctrl.sv
// Warm-boot sequencer: wraps each bitstream load in fabric-reset holds and falls back to BOOT_SLOT on a load error.
// Latency: boot event 2-3 cycles after boot_i rises; PRE_RST/POST_RST each last RESET_CYCLES; REQ/WAIT last until the loader answers.
// Backpressure: load_req_o/load_slot_o are held until load_ack_i; boot events arriving while busy are dropped, not queued.
module warmboot_ctrl #(
    parameter int unsigned SLOT_BITS    = 4,
    parameter int unsigned BOOT_SLOT    = 0,
    parameter int unsigned RESET_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 boot_i,
    input  logic [SLOT_BITS-1:0] slot_i,
    output logic                 reset_o,
    output logic                 configured_o,
    output logic                 load_req_o,
    output logic [SLOT_BITS-1:0] load_slot_o,
    input  logic                 load_ack_i,
    input  logic                 load_done_i,
    input  logic                 load_err_i,
    output logic                 fail_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_RST  = 3'd1,
        REQ      = 3'd2,
        WAIT     = 3'd3,
        POST_RST = 3'd4,
        FAIL     = 3'd5
    } state_t;

    localparam logic [SLOT_BITS-1:0] BOOT_SLOT_V = SLOT_BITS'(BOOT_SLOT);
    localparam logic [7:0]           HOLD_INIT   = 8'(RESET_CYCLES);

    // boot_i synchronizer and edge detector
    logic boot_sync1_q;
    logic boot_sync2_q;
    logic boot_prev_q;
    logic boot_evt;

    // FSM state and its companions
    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [SLOT_BITS-1:0] target_q, target_d;
    logic                 reset_q, reset_d;
    logic                 configured_q, configured_d;

    // Bring boot_i into the clock domain and keep one cycle of history for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            boot_sync1_q <= 1'b0;
            boot_sync2_q <= 1'b0;
            boot_prev_q  <= 1'b0;
        end else begin
            boot_sync1_q <= boot_i;
            boot_sync2_q <= boot_sync1_q;
            boot_prev_q  <= boot_sync2_q;
        end
    end

    assign boot_evt = boot_sync2_q & ~boot_prev_q;

    // State register; reset parks the FSM at the start of a cold boot of the fallback slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= PRE_RST;
            cnt_q        <= HOLD_INIT;
            target_q     <= BOOT_SLOT_V;
            reset_q      <= 1'b1;
            configured_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            reset_q      <= reset_d;
            configured_q <= configured_d;
        end
    end

    // Next-state logic; registered outputs are derived from the next state so they line up with state_q.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;

        case (state_q)
            IDLE: begin
                // slot_i is only sampled when the event is accepted, so a
                // dropped event can never disturb the slot being loaded.
                if (boot_evt && configured_q) begin
                    state_d  = PRE_RST;
                    cnt_d    = HOLD_INIT;
                    target_d = slot_i;
                end
            end

            PRE_RST: begin
                if (cnt_q <= 8'd1) begin
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            REQ: begin
                if (load_ack_i) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                // An error wins over a simultaneous done: the image is suspect.
                if (load_err_i) begin
                    if (target_q != BOOT_SLOT_V) begin
                        target_d = BOOT_SLOT_V;
                        state_d  = REQ;
                    end else begin
                        state_d = FAIL;
                    end
                end else if (load_done_i) begin
                    state_d = POST_RST;
                    cnt_d   = HOLD_INIT;
                end
            end

            POST_RST: begin
                if (cnt_q <= 8'd1) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            FAIL: begin
                state_d = FAIL;
            end

            default: begin
                // Unreachable encodings recover through a cold boot.
                state_d  = PRE_RST;
                cnt_d    = HOLD_INIT;
                target_d = BOOT_SLOT_V;
            end
        endcase

        reset_d      = (state_d != IDLE);
        configured_d = (state_d == IDLE);
    end

    // Request-side outputs are gated by rst_i so an abort takes effect within the same cycle.
    assign reset_o      = reset_q;
    assign configured_o = configured_q;
    assign load_req_o   = (state_q == REQ) && !rst_i;
    assign load_slot_o  = load_req_o ? target_q : '0;
    assign fail_o       = (state_q == FAIL) && !rst_i;

endmodule
